// File: rtl/wallace_tree_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier: Wallace-tree reduction of AND partial products,
// final carry-propagate add, product and valid registered on one clock edge.
module wallace_tree_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     Multiplier,
  input  logic [WIDTH-1:0]     Multiplicant,
  output logic [2*WIDTH-1:0]   result,
  output logic                 out_valid
);

  localparam int PW     = 2 * WIDTH;
  localparam int HMAX   = WIDTH + 2;
  localparam int GROUPS = HMAX / 3 + 1;
  // Ten layers reduce column heights up to 63, ample for any practical WIDTH.
  localparam int LAYERS = 10;

  logic [PW-1:0] row_a;
  logic [PW-1:0] row_b;
  logic [PW-1:0] product;

  always_comb begin
    logic bits [PW][HMAX];
    logic nb   [PW][HMAX];
    int   ht   [PW];
    int   nh   [PW];
    logic tall;
    logic a, b, ci;

    for (int c = 0; c < PW; c++) begin
      ht[c] = 0;
      nh[c] = 0;
      for (int k = 0; k < HMAX; k++) begin
        bits[c][k] = 1'b0;
        nb[c][k]   = 1'b0;
      end
    end
    a  = 1'b0;
    b  = 1'b0;
    ci = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bits[i+j][ht[i+j]] = Multiplier[j] & Multiplicant[i];
        ht[i+j]            = ht[i+j] + 1;
      end
    end

    // Column heights depend only on WIDTH, so every layer is fixed wiring.
    for (int l = 0; l < LAYERS; l++) begin
      tall = 1'b0;
      for (int c = 0; c < PW; c++) begin
        if (ht[c] > 2) tall = 1'b1;
      end
      if (tall) begin
        for (int c = 0; c < PW; c++) begin
          nh[c] = 0;
          for (int k = 0; k < HMAX; k++) nb[c][k] = 1'b0;
        end
        for (int c = 0; c < PW; c++) begin
          for (int g = 0; g < GROUPS; g++) begin
            if (3*g + 2 < ht[c]) begin
              a  = bits[c][3*g];
              b  = bits[c][3*g+1];
              ci = bits[c][3*g+2];
              nb[c][nh[c]] = a ^ b ^ ci;
              nh[c]        = nh[c] + 1;
              if (c < PW-1) begin
                nb[c+1][nh[c+1]] = (a & b) | (ci & (a ^ b));
                nh[c+1]          = nh[c+1] + 1;
              end
            end else if (3*g + 2 == ht[c]) begin
              a = bits[c][3*g];
              b = bits[c][3*g+1];
              nb[c][nh[c]] = a ^ b;
              nh[c]        = nh[c] + 1;
              if (c < PW-1) begin
                nb[c+1][nh[c+1]] = a & b;
                nh[c+1]          = nh[c+1] + 1;
              end
            end else if (3*g + 1 == ht[c]) begin
              nb[c][nh[c]] = bits[c][3*g];
              nh[c]        = nh[c] + 1;
            end
          end
        end
        for (int c = 0; c < PW; c++) begin
          ht[c] = nh[c];
          for (int k = 0; k < HMAX; k++) bits[c][k] = nb[c][k];
        end
      end
    end

    for (int c = 0; c < PW; c++) begin
      row_a[c] = bits[c][0];
      row_b[c] = bits[c][1];
    end
  end

  // The carry out of the top column cannot be set: the true product fits in PW bits.
  assign product = row_a + row_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      result    <= product;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Directed-vector and stream bench for wallace_tree_multiplier.
module tb_wallace_tree_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] Multiplier = '0;
  logic [15:0] Multiplicant = '0;
  logic [31:0] result;
  logic        out_valid;

  int total  = 0;
  int passed = 0;

  wallace_tree_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .Multiplier   (Multiplier),
    .Multiplicant (Multiplicant),
    .result       (result),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic v, input logic r);
    @(negedge clk);
    Multiplier   = a;
    Multiplicant = b;
    in_valid     = v;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pa, pb;
    logic        pv;
    logic [15:0] a, b;
    logic        v;
    int          s;

    vecs.push_back('{"zero_x_ffff", 16'h0000, 16'hFFFF, 32'h00000000});
    vecs.push_back('{"one_x_abcd",  16'h0001, 16'hABCD, 32'h0000ABCD});
    vecs.push_back('{"ffff_x_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{"8000_x_0002", 16'h8000, 16'h0002, 32'h00010000});
    vecs.push_back('{"00ff_x_00ff", 16'h00FF, 16'h00FF, 32'h0000FE01});
    vecs.push_back('{"aaaa_x_5555", 16'hAAAA, 16'h5555, 32'h38E31C72});
    vecs.push_back('{"8000_x_8000", 16'h8000, 16'h8000, 32'h40000000});
    vecs.push_back('{"abcd_x_one",  16'hABCD, 16'h0001, 32'h0000ABCD});
    vecs.push_back('{"ffff_x_zero", 16'hFFFF, 16'h0000, 32'h00000000});
    vecs.push_back('{"1234_x_5678", 16'h1234, 16'h5678, 32'h06260060});

    // Reset held for two edges overrides live operands.
    step(16'h1234, 16'h5678, 1'b1, 1'b1);
    check("reset1_result", result, 32'h0);
    check("reset1_valid", {31'b0, out_valid}, 32'h0);
    step(16'h1234, 16'h5678, 1'b1, 1'b1);
    check("reset2_result", result, 32'h0);
    check("reset2_valid", {31'b0, out_valid}, 32'h0);
    step(16'h1234, 16'h5678, 1'b1, 1'b0);
    check("post_reset_result", result, 32'h06260060);
    check("post_reset_valid", {31'b0, out_valid}, 32'h1);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, i[0], 1'b0);
      check(vecs[i].name, result, vecs[i].exp);
      check({vecs[i].name, "_valid"}, {31'b0, out_valid}, {31'b0, i[0]});
    end

    // Back-to-back: each edge captures the pair driven just before it.
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      v = 1'($urandom);
      step(a, b, v, 1'b0);
      check("b2b_result", result, 32'(a) * 32'(b));
      check("b2b_valid", {31'b0, out_valid}, {31'b0, v});
    end

    // Random regression, half the operands from signed sources.
    for (int i = 0; i < 10000; i++) begin
      if (i[0]) begin
        s = $random;
        a = 16'(s);
        s = $random;
        b = 16'(s);
      end else begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
      end
      step(a, b, 1'b1, 1'b0);
      check("rand_result", result, 32'(a) * 32'(b));
    end

    // Mid-stream reset discards the in-flight product, then the stream resumes.
    pa = 16'hBEEF; pb = 16'hCAFE; pv = 1'b1;
    step(pa, pb, pv, 1'b0);
    check("pre_mid_reset", result, 32'(pa) * 32'(pb));
    step(16'h7777, 16'h9999, 1'b1, 1'b1);
    check("mid_reset_result", result, 32'h0);
    check("mid_reset_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      step(a, b, 1'b1, 1'b0);
      check("resume_result", result, 32'(a) * 32'(b));
      check("resume_valid", {31'b0, out_valid}, 32'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
